fir_tap_buffer: RTL and testbench
=================================

# fir_tap_buffer

Coefficient store for the FIR accelerator. It sits between the H-stream source, which delivers 32-bit words each packing two 16-bit taps, and the FIR datapath, which reads all taps in parallel. It fills `NB_TAPS` tap registers after a start request and reports completion through `done_o`. The controller's tap-buffer flags are driven from `done_o` to advance from the tap-loading phase to the compute phase.

## Interface
Parameters:
- `NB_TAPS`, default 50: number of 16-bit taps stored; must be ≥ 2.
- `TAP_WIDTH`, default 16: tap width in bits. It is fixed at 16 because the 32-bit word packing is two taps.

Ports:
- `clk_i`, input, 1: clock. All logic is on the rising edge.
- `rst_i`, input, 1: reset, synchronous and active-high.
- `clear_i`, input, 1: synchronous soft clear from the controller. Same effect as `rst_i`.
- `start_i`, input, 1: single-cycle request to (re)load the taps.
- `h_valid_i`, input, 1: H-stream word valid.
- `h_ready_o`, output, 1: H-stream word ready.
- `h_data_i`, input, 32: H-stream word. Bits [15:0] hold the even tap, bits [31:16] the odd tap.
- `taps_o`, output, `NB_TAPS`×`TAP_WIDTH`: tap registers. `taps_o[i]` is h[i].
- `done_o`, output, 1: one-cycle pulse when the last tap is written.
- `full_o`, output, 1: level, asserted while the buffer holds a complete tap set.

## Operation
- Number of words: `NB_WORDS` = ceil(`NB_TAPS`/2). This is 25 for the default.
- Word counter: `word_cnt`, width $clog2(`NB_WORDS`)+1, counts 0..`NB_WORDS`-1.
- State machine:
  - IDLE:
    - `start_i` → LOAD, `word_cnt`=0.
  - LOAD:
    - `h_ready_o`=1.
    - On handshake (`h_valid_i` & `h_ready_o`):
      - `taps_o[2*word_cnt]` ← `h_data_i[15:0]`.
      - `taps_o[2*word_cnt+1]` ← `h_data_i[31:16]`, only if 2*`word_cnt`+1 < `NB_TAPS`. Otherwise the upper half is discarded, which happens for odd `NB_TAPS`.
      - `word_cnt` increments.
    - Handshake with `word_cnt`==`NB_WORDS`-1 → FULL, with `done_o` set for the next cycle.
    - `start_i` in LOAD is ignored.
  - FULL:
    - `full_o`=1, `h_ready_o`=0, taps held.
    - `start_i` → LOAD, `word_cnt`=0. Old taps remain visible until they are overwritten word by word.
- `rst_i` or `clear_i` (takes priority over everything) → IDLE:
  - `word_cnt`=0
  - all taps 0
  - `done_o`=0, `full_o`=0
  - any in-flight handshake in the same cycle is not accepted.
- `h_valid_i` outside LOAD is ignored, and no data is consumed.

## Timing
- Reset values: `h_ready_o`=0, `done_o`=0, `full_o`=0, `taps_o`=all 0, state IDLE.
- `h_ready_o` is a decode of the registered state only. There is no combinational path from `h_valid_i` or `start_i`.
- `h_ready_o` rises the cycle after `start_i` is sampled in IDLE or FULL.
- Throughput is 1 word/cycle with `h_valid_i` held high. A full load takes `NB_WORDS` cycles after `h_ready_o` rises.
- Tap writes are registered. `taps_o` reflects a handshaked word in the following cycle.
- `done_o` is registered:
  - high exactly one cycle, the cycle after the last handshake;
  - in that same cycle `full_o` rises and `h_ready_o` falls.
- A `start_i` in the same cycle as `done_o` (state FULL) is honoured: → LOAD the next cycle.
- `clear_i` in the cycle of the last handshake: no `done_o`, and the buffer ends in IDLE.

## Test plan
- **Default load:** `NB_TAPS`=50, `start_i` pulse, 25 back-to-back words, word k = {16'(2k+1), 16'(2k)}.
  - Required: `taps_o[i]`=i for i=0..49.
  - `done_o` high exactly one cycle, the cycle after handshake 25; `full_o`=1 and `h_ready_o`=0 from then on.
- **Odd count:** `NB_TAPS`=5, words 32'hBBBB_0000, 32'h2222_1111, 32'hDEAD_3333.
  - Required: taps = 0000, BBBB, 1111, 2222, 3333; the DEAD half is dropped.
  - `done_o` follows the 3rd handshake.
- **Backpressure:** `h_valid_i` follows pattern 1,0,0,1,… during a 50-tap load.
  - Required: taps correct, no word skipped or duplicated.
  - `done_o` one cycle after the 25th accepted word; `h_ready_o` stays 1 throughout LOAD.
- **Clear mid-load:** `clear_i` after 10 words.
  - Required next cycle: IDLE, all taps 0, `h_ready_o`=0, `full_o`=0, and no `done_o` ever.
  - A subsequent `start_i` plus 25 words loads correctly.
- **Reload:** in FULL with taps=i, `start_i`, then 25 words of value 32'hFFFF_FFFF.
  - Required: `full_o` drops the cycle after `start_i`; after the 1st handshake, taps 0–1 = FFFF while taps 2–49 still hold i.
  - After completion all taps = FFFF and `done_o` pulses once.
- **Reset/ignored inputs:** `h_valid_i`=1 in IDLE for 5 cycles, then `rst_i` mid-load.
  - Required: no data accepted in IDLE; after `rst_i`, all outputs are at reset values.

Source files
------------

// File: rtl/fir_tap_buffer.sv
// FIR coefficient store: unpacks 32-bit H-stream words into NB_TAPS
// parallel tap registers and flags completion with done_o/full_o.
module fir_tap_buffer #(
  parameter int NB_TAPS   = 50,
  parameter int TAP_WIDTH = 16
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                clear_i,
  input  logic                                start_i,
  input  logic                                h_valid_i,
  output logic                                h_ready_o,
  input  logic [31:0]                         h_data_i,
  output logic [NB_TAPS-1:0][TAP_WIDTH-1:0]   taps_o,
  output logic                                done_o,
  output logic                                full_o
);

  localparam int NB_WORDS = (NB_TAPS + 1) / 2;
  localparam int CW       = $clog2(NB_WORDS) + 1;
  localparam logic [CW-1:0] LAST = CW'(NB_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FULL
  } state_e;

  state_e                            state_q, state_d;
  logic [CW-1:0]                     cnt_q, cnt_d;
  logic [NB_TAPS-1:0][TAP_WIDTH-1:0] taps_q, taps_d;
  logic                              done_q, done_d;
  logic                              hs;
  logic                              kill;

  assign kill = rst_i | clear_i;
  assign hs   = h_valid_i & (state_q == LOAD);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (hs) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = FULL;
            done_d  = 1'b1;
          end
        end
      end
      FULL: begin
        if (start_i) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Tap i lives in word i/2; an odd tap count never maps the last upper half.
  always_comb begin
    taps_d = taps_q;
    for (int i = 0; i < NB_TAPS; i++) begin
      if (hs && (cnt_q == CW'(i / 2))) begin
        if (i % 2 == 1) begin
          taps_d[i] = h_data_i[31:16];
        end else begin
          taps_d[i] = h_data_i[15:0];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (kill) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      taps_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      taps_q  <= taps_d;
      done_q  <= done_d;
    end
  end

  assign h_ready_o = (state_q == LOAD);
  assign full_o    = (state_q == FULL);
  assign done_o    = done_q;
  assign taps_o    = taps_q;

endmodule

// File: tb/tb_fir_tap_buffer.sv
// Scoreboard bench for fir_tap_buffer: 50-tap and 5-tap instances,
// expected tap sets queued by stimulus and checked on each done_o pulse.
module tb_fir_tap_buffer;

  localparam int N  = 50;
  localparam int N5 = 5;
  localparam int W  = N * 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, clr;
  logic                 start, hv, ready, done, full;
  logic [31:0]          hd;
  logic [N-1:0][15:0]   taps;
  logic                 start5, hv5, ready5, done5, full5;
  logic [31:0]          hd5;
  logic [N5-1:0][15:0]  taps5;

  fir_tap_buffer #(.NB_TAPS(N), .TAP_WIDTH(16)) u_dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clr), .start_i(start),
    .h_valid_i(hv), .h_ready_o(ready), .h_data_i(hd),
    .taps_o(taps), .done_o(done), .full_o(full)
  );

  fir_tap_buffer #(.NB_TAPS(N5), .TAP_WIDTH(16)) u_dut5 (
    .clk_i(clk), .rst_i(rst), .clear_i(clr), .start_i(start5),
    .h_valid_i(hv5), .h_ready_o(ready5), .h_data_i(hd5),
    .taps_o(taps5), .done_o(done5), .full_o(full5)
  );

  int errs   = 0;
  int checks = 0;

  logic [N-1:0][15:0]  exp_q[$];
  logic [N5-1:0][15:0] exp5_q[$];
  logic [N-1:0][15:0]  e_a;
  logic [N5-1:0][15:0] e_b;
  logic [31:0]         wbuf[N/2];
  logic                dprev = 1'b0;
  logic                dprev5 = 1'b0;

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [N-1:0][15:0] ramp(input int off);
    logic [N-1:0][15:0] r;
    for (int i = 0; i < N; i++) r[i] = 16'(i + off);
    return r;
  endfunction

  task automatic fill_ramp(input int off);
    for (int k = 0; k < N / 2; k++)
      wbuf[k] = {16'(2 * k + 1 + off), 16'(2 * k + off)};
  endtask

  // All drive tasks start and end at posedge+1.
  task automatic start_a();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic load_a(input int gap);
    for (int k = 0; k < N / 2; k++) begin
      hv = 1'b1;
      hd = wbuf[k];
      @(posedge clk); #1;
      if (k < N / 2 - 1) begin
        hv = 1'b0;
        hd = 32'hDEAD_BEEF;
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          chk("ready_in_gap", W'(ready), W'(1'b1));
          @(posedge clk); #1;
        end
      end
    end
    hv = 1'b0;
  endtask

  task automatic check_done_a(input string nm);
    @(negedge clk);
    chk({nm, "_done"}, W'(done), W'(1'b1));
    chk({nm, "_full"}, W'(full), W'(1'b1));
    chk({nm, "_ready"}, W'(ready), W'(1'b0));
    @(negedge clk);
    chk({nm, "_done_low"}, W'(done), W'(1'b0));
    chk({nm, "_full_hold"}, W'(full), W'(1'b1));
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (done) begin
      chk("done_width", W'(dprev), W'(1'b0));
      if (exp_q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL done_unexpected: got done=1 expected no pulse");
      end else begin
        e_a = exp_q.pop_front();
        chk("sb_taps", W'(taps), W'(e_a));
        chk("sb_full", W'(full), W'(1'b1));
        chk("sb_ready", W'(ready), W'(1'b0));
      end
    end
    dprev = done;
  end

  always @(negedge clk) begin
    if (done5) begin
      chk("done5_width", W'(dprev5), W'(1'b0));
      if (exp5_q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL done5_unexpected: got done=1 expected no pulse");
      end else begin
        e_b = exp5_q.pop_front();
        chk("sb5_taps", W'(taps5), W'(e_b));
        chk("sb5_full", W'(full5), W'(1'b1));
      end
    end
    dprev5 = done5;
  end

  initial begin
    logic [N-1:0][15:0]  mid;
    logic [N5-1:0][15:0] odd_exp;
    rst = 1'b1; clr = 1'b0;
    start = 1'b0; hv = 1'b0; hd = '0;
    start5 = 1'b0; hv5 = 1'b0; hd5 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_ready", W'(ready), W'(1'b0));
    chk("rst_done", W'(done), W'(1'b0));
    chk("rst_full", W'(full), W'(1'b0));
    chk("rst_taps", W'(taps), '0);
    chk("rst5_taps", W'(taps5), '0);
    @(posedge clk); #1;

    // Backpressure 1,0,0 with distinct values
    fill_ramp(256);
    exp_q.push_back(ramp(256));
    start_a();
    @(negedge clk);
    chk("bp_ready_rise", W'(ready), W'(1'b1));
    @(posedge clk); #1;
    load_a(2);
    check_done_a("bp");

    // Default back-to-back load, taps = i
    fill_ramp(0);
    exp_q.push_back(ramp(0));
    start_a();
    load_a(0);
    check_done_a("dflt");

    // Reload from FULL with all-ones
    mid = ramp(0);
    mid[0] = 16'hFFFF;
    mid[1] = 16'hFFFF;
    exp_q.push_back({N{16'hFFFF}});
    start_a();
    hv = 1'b1;
    hd = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("rl_full_drop", W'(full), W'(1'b0));
    chk("rl_old_taps", W'(taps), W'(ramp(0)));
    @(posedge clk); #1;
    @(negedge clk);
    chk("rl_first_word", W'(taps), W'(mid));
    for (int k = 1; k < N / 2; k++) begin
      @(posedge clk); #1;
    end
    hv = 1'b0;
    check_done_a("rl");

    // Clear after 10 words, in-flight word rejected
    fill_ramp(0);
    start_a();
    for (int k = 0; k < 10; k++) begin
      hv = 1'b1; hd = wbuf[k];
      @(posedge clk); #1;
    end
    clr = 1'b1; hd = wbuf[10];
    @(posedge clk); #1;
    clr = 1'b0; hv = 1'b0;
    @(negedge clk);
    chk("clr_taps", W'(taps), '0);
    chk("clr_ready", W'(ready), W'(1'b0));
    chk("clr_full", W'(full), W'(1'b0));
    chk("clr_done", W'(done), W'(1'b0));
    @(posedge clk); #1;
    exp_q.push_back(ramp(0));
    start_a();
    load_a(0);
    check_done_a("clr_reload");

    // Clear coincident with the last handshake
    start_a();
    for (int k = 0; k < N / 2; k++) begin
      hv = 1'b1; hd = wbuf[k];
      if (k == N / 2 - 1) clr = 1'b1;
      @(posedge clk); #1;
    end
    clr = 1'b0; hv = 1'b0;
    @(negedge clk);
    chk("clrlast_done", W'(done), W'(1'b0));
    chk("clrlast_full", W'(full), W'(1'b0));
    chk("clrlast_taps", W'(taps), '0);
    @(posedge clk); #1;

    // Valid in IDLE ignored, then reset mid-load
    hv = 1'b1; hd = 32'h1234_5678;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("idle_ready", W'(ready), W'(1'b0));
      chk("idle_taps", W'(taps), '0);
    end
    @(posedge clk); #1;
    hv = 1'b0;
    start_a();
    for (int k = 0; k < 3; k++) begin
      hv = 1'b1; hd = wbuf[k];
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; hv = 1'b0;
    @(negedge clk);
    chk("mrst_ready", W'(ready), W'(1'b0));
    chk("mrst_done", W'(done), W'(1'b0));
    chk("mrst_full", W'(full), W'(1'b0));
    chk("mrst_taps", W'(taps), '0);
    @(posedge clk); #1;

    // Odd tap count on the 5-tap instance
    odd_exp = {16'h3333, 16'h2222, 16'h1111, 16'hBBBB, 16'h0000};
    exp5_q.push_back(odd_exp);
    start5 = 1'b1;
    @(posedge clk); #1;
    start5 = 1'b0;
    hv5 = 1'b1; hd5 = 32'hBBBB_0000;
    @(posedge clk); #1;
    hd5 = 32'h2222_1111;
    @(posedge clk); #1;
    hd5 = 32'hDEAD_3333;
    @(posedge clk); #1;
    hv5 = 1'b0;
    @(negedge clk);
    chk("odd_done", W'(done5), W'(1'b1));
    chk("odd_ready", W'(ready5), W'(1'b0));
    chk("odd_taps", W'(taps5), W'(odd_exp));
    @(negedge clk);
    chk("odd_done_low", W'(done5), W'(1'b0));
    chk("odd_full_hold", W'(full5), W'(1'b1));

    repeat (3) @(negedge clk);
    chk("sb_pending", W'(exp_q.size()), '0);
    chk("sb5_pending", W'(exp5_q.size()), '0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
